// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one registered 8-bit ALU.
// Routes each result back to its issuer; counts grants per requester.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [2:0]       req0_op,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [7:0]       rsp0_result,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic [2:0]       req1_op,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [7:0]       rsp1_result,
    output logic             rsp1_zero,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_result,
    input  logic             alu_zero,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic gnt0;
    logic gnt1;
    logic gnt_any;
    logic last_gnt;
    logic iss_v_q;
    logic iss_id_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case ({req1_valid, req0_valid})
                2'b01:   gnt0 = 1'b1;
                2'b10:   gnt1 = 1'b1;
                2'b11: begin
                    if (RR_EN && !last_gnt) gnt1 = 1'b1;
                    else                    gnt0 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt_any    = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Steer the winner's operands to the ALU; idle drives the zero op
    always_comb begin
        alu_a  = 8'd0;
        alu_b  = 8'd0;
        alu_op = 3'd7;
        if (gnt0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end else if (gnt1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    // Remember the previous winner; reset to 1 so req0 wins first
    always_ff @(posedge clk) begin
        if (rst)          last_gnt <= 1'b1;
        else if (gnt_any) last_gnt <= gnt1;
    end

    // Track which requester owns the ALU result next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_v_q  <= 1'b0;
            iss_id_q <= 1'b0;
        end else begin
            iss_v_q  <= gnt_any;
            iss_id_q <= gnt1;
        end
    end

    // Saturating completed-handshake counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_valid && gnt0 && cnt0_q != CNT_MAX)
                cnt0_q <= cnt0_q + CNT_ONE;
            if (req1_valid && gnt1 && cnt1_q != CNT_MAX)
                cnt1_q <= cnt1_q + CNT_ONE;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;

    assign rsp0_valid  = iss_v_q & ~iss_id_q;
    assign rsp1_valid  = iss_v_q & iss_id_q;
    assign rsp0_result = rsp0_valid ? alu_result : 8'd0;
    assign rsp1_result = rsp1_valid ? alu_result : 8'd0;
    assign rsp0_zero   = rsp0_valid & alu_zero;
    assign rsp1_zero   = rsp1_valid & alu_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances
// side by side, each behind its own registered ALU model.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v0, v1;
    logic [7:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;

    logic       r_rdy0, r_rdy1, r_rv0, r_rv1, r_z0, r_z1;
    logic [7:0] r_res0, r_res1, r_aa, r_ab;
    logic [2:0] r_aop;
    logic [7:0] r_ares = 8'd0;
    logic       r_azero = 1'b0;
    logic [15:0] r_c0, r_c1;

    logic       f_rdy0, f_rdy1, f_rv0, f_rv1, f_z0, f_z1;
    logic [7:0] f_res0, f_res1, f_aa, f_ab;
    logic [2:0] f_aop;
    logic [7:0] f_ares = 8'd0;
    logic       f_azero = 1'b0;
    logic [1:0] f_c0, f_c1;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.RR_EN(1'b1), .CNT_W(16)) dut_rr (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_op(op0),
        .req0_ready(r_rdy0), .rsp0_valid(r_rv0),
        .rsp0_result(r_res0), .rsp0_zero(r_z0),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_op(op1),
        .req1_ready(r_rdy1), .rsp1_valid(r_rv1),
        .rsp1_result(r_res1), .rsp1_zero(r_z1),
        .alu_a(r_aa), .alu_b(r_ab), .alu_op(r_aop),
        .alu_result(r_ares), .alu_zero(r_azero),
        .gnt_cnt0(r_c0), .gnt_cnt1(r_c1)
    );

    alu_arbiter #(.RR_EN(1'b0), .CNT_W(2)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_op(op0),
        .req0_ready(f_rdy0), .rsp0_valid(f_rv0),
        .rsp0_result(f_res0), .rsp0_zero(f_z0),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_op(op1),
        .req1_ready(f_rdy1), .rsp1_valid(f_rv1),
        .rsp1_result(f_res1), .rsp1_zero(f_z1),
        .alu_a(f_aa), .alu_b(f_ab), .alu_op(f_aop),
        .alu_result(f_ares), .alu_zero(f_azero),
        .gnt_cnt0(f_c0), .gnt_cnt1(f_c1)
    );

    function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b,
                                         logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return a & b;
            3'd5:    return a << 1;
            3'd6:    return a >> 1;
            default: return 8'd0;
        endcase
    endfunction

    // Registered ALU models
    always @(posedge clk) begin
        r_ares  <= alu_f(r_aa, r_ab, r_aop);
        r_azero <= (alu_f(r_aa, r_ab, r_aop) == 8'd0);
        f_ares  <= alu_f(f_aa, f_ab, f_aop);
        f_azero <= (alu_f(f_aa, f_ab, f_aop) == 8'd0);
    end

    // Reference model state, index 0 = round-robin, 1 = fixed priority
    int m_last[2];
    int m_pv[2];
    int m_pid[2];
    int m_pres[2];
    int m_c0[2];
    int m_c1[2];
    int m_g[2];
    int m_rr[2]   = '{1, 0};
    int m_cmax[2] = '{65535, 3};

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_gnt(int k);
        if (rst) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (!v0 && !v1) return -1;
        if (m_rr[k] != 0) return (m_last[k] == 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic check_inst(input int k, input string nm,
        input int rdy0, input int rdy1, input int aa, input int ab,
        input int aop, input int rv0, input int res0, input int z0,
        input int rv1, input int res1, input int z1,
        input int c0, input int c1);
        int g;
        int ev0, ev1, ez;
        g   = exp_gnt(k);
        ev0 = (m_pv[k] != 0 && m_pid[k] == 0) ? 1 : 0;
        ev1 = (m_pv[k] != 0 && m_pid[k] == 1) ? 1 : 0;
        ez  = (m_pres[k] == 0) ? 1 : 0;
        chk({nm, "_rdy0"}, rdy0, (g == 0) ? 1 : 0);
        chk({nm, "_rdy1"}, rdy1, (g == 1) ? 1 : 0);
        chk({nm, "_alu_a"}, aa, (g == 0) ? int'(a0) : (g == 1) ? int'(a1) : 0);
        chk({nm, "_alu_b"}, ab, (g == 0) ? int'(b0) : (g == 1) ? int'(b1) : 0);
        chk({nm, "_alu_op"}, aop, (g == 0) ? int'(op0) : (g == 1) ? int'(op1) : 7);
        chk({nm, "_rv0"}, rv0, ev0);
        chk({nm, "_res0"}, res0, ev0 ? m_pres[k] : 0);
        chk({nm, "_z0"}, z0, ev0 ? ez : 0);
        chk({nm, "_rv1"}, rv1, ev1);
        chk({nm, "_res1"}, res1, ev1 ? m_pres[k] : 0);
        chk({nm, "_z1"}, z1, ev1 ? ez : 0);
        chk({nm, "_cnt0"}, c0, m_c0[k]);
        chk({nm, "_cnt1"}, c1, m_c1[k]);
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int g;
            g = exp_gnt(k);
            m_g[k] = g;
            if (rst) begin
                m_last[k] = 1;
                m_pv[k]   = 0;
                m_pid[k]  = 0;
                m_c0[k]   = 0;
                m_c1[k]   = 0;
            end else begin
                m_pv[k]  = (g >= 0) ? 1 : 0;
                m_pid[k] = (g == 1) ? 1 : 0;
                if (g == 0) m_pres[k] = int'(alu_f(a0, b0, op0));
                if (g == 1) m_pres[k] = int'(alu_f(a1, b1, op1));
                if (g >= 0) m_last[k] = g;
                if (g == 0 && m_c0[k] < m_cmax[k]) m_c0[k]++;
                if (g == 1 && m_c1[k] < m_cmax[k]) m_c1[k]++;
            end
        end
    endtask

    // One clock: check combinational and registered outputs, then advance
    task automatic cyc();
        #1;
        check_inst(0, "rr", r_rdy0, r_rdy1, r_aa, r_ab, r_aop, r_rv0,
                   r_res0, r_z0, r_rv1, r_res1, r_z1, r_c0, r_c1);
        check_inst(1, "fp", f_rdy0, f_rdy1, f_aa, f_ab, f_aop, f_rv0,
                   f_res0, f_z0, f_rv1, f_res1, f_z1, f_c0, f_c1);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op);
        v0 = v; a0 = a; b0 = b; op0 = op;
    endtask

    task automatic set1(input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op);
        v1 = v; a1 = a; b1 = b; op1 = op;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1; m_pv[k] = 0; m_pid[k] = 0; m_pres[k] = 0;
            m_c0[k] = 0; m_c1[k] = 0; m_g[k] = -1;
        end
        rst = 1'b1;
        set0(1'b0, 8'd0, 8'd0, 3'd0);
        set1(1'b0, 8'd0, 8'd0, 3'd0);
        @(negedge clk);
        cyc();
        set0(1'b1, 8'd9, 8'd9, 3'd0);
        #1;
        chk("rst_rdy0", r_rdy0, 0);
        chk("rst_alu_op", r_aop, 7);
        cyc();
        rst = 1'b0;
        set0(1'b0, 8'd0, 8'd0, 3'd0);
        #1;
        chk("post_rst_rv0", r_rv0, 0);
        chk("post_rst_cnt0", r_c0, 0);
        cyc();

        // single add
        set0(1'b1, 8'd3, 8'd4, 3'd0);
        #1 chk("add_rdy", r_rdy0, 1);
        cyc();
        set0(1'b0, 8'd0, 8'd0, 3'd0);
        chk("add_rv", r_rv0, 1);
        chk("add_res", r_res0, 7);
        chk("add_zero", r_z0, 0);
        chk("add_rv1", r_rv1, 0);
        cyc();

        // zero flag and wrap on requester 1
        set1(1'b1, 8'd5, 8'd5, 3'd1);
        cyc();
        chk("sub_res", r_res1, 0);
        chk("sub_zero", r_z1, 1);
        set1(1'b1, 8'd200, 8'd100, 3'd0);
        cyc();
        set1(1'b0, 8'd0, 8'd0, 3'd0);
        chk("wrap_res", r_res1, 44);
        chk("wrap_zero", r_z1, 0);
        cyc();

        // contention under round-robin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set0(1'b1, 8'd10, 8'd1, 3'd0);
        set1(1'b1, 8'hF0, 8'h0F, 3'd3);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_rdy0", r_rdy0, (i % 2 == 0) ? 1 : 0);
            if (i > 0)
                chk("cont_rsp", r_res0 | r_res1, (i % 2 == 1) ? 11 : 255);
            cyc();
        end
        set0(1'b0, 8'd0, 8'd0, 3'd0);
        set1(1'b0, 8'd0, 8'd0, 3'd0);
        chk("cont_last_rsp", r_res1, 255);
        chk("cont_cnt0", r_c0, 3);
        chk("cont_cnt1", r_c1, 3);
        cyc();

        // fixed priority starves requester 1
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set0(1'b1, 8'd1, 8'd2, 3'd2);
        set1(1'b1, 8'd3, 8'd4, 3'd4);
        for (int i = 0; i < 4; i++) begin
            #1 chk("fp_rdy1", f_rdy1, 0);
            cyc();
        end
        chk("fp_cnt1", f_c1, 0);
        set0(1'b0, 8'd0, 8'd0, 3'd0);
        #1 chk("fp_rdy1_free", f_rdy1, 1);
        cyc();
        set1(1'b0, 8'd0, 8'd0, 3'd0);
        cyc();

        // reset mid-flight
        set0(1'b1, 8'h81, 8'd0, 3'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set0(1'b0, 8'd0, 8'd0, 3'd0);
        #1;
        chk("midrst_rv0", r_rv0, 0);
        chk("midrst_cnt0", r_c0, 0);
        cyc();
        chk("midrst_rv0_late", r_rv0, 0);
        set0(1'b1, 8'h81, 8'd0, 3'd6);
        cyc();
        set0(1'b0, 8'd0, 8'd0, 3'd0);
        chk("shr_res", r_res0, 8'h40);

        // idle
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_op", r_aop, 7);
            chk("idle_rv", r_rv0 | r_rv1, 0);
        end

        // saturation with a 2-bit counter
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set0(1'b1, 8'd1, 8'd1, 3'd0);
        for (int i = 0; i < 5; i++) cyc();
        set0(1'b0, 8'd0, 8'd0, 3'd0);
        chk("sat_cnt0", f_c0, 3);
        cyc();
        chk("sat_hold", f_c0, 3);
        chk("nosat_cnt0", r_c0, 5);

        // randomized traffic; a stalled requester keeps its request
        for (int i = 0; i < 400; i++) begin
            if (!(v0 && m_g[0] != 0)) begin
                v0  = 1'($urandom_range(0, 1));
                a0  = 8'($urandom);
                b0  = 8'($urandom);
                op0 = 3'($urandom);
            end
            if (!(v1 && m_g[0] != 1)) begin
                v1  = 1'($urandom_range(0, 1));
                a1  = 8'($urandom);
                b1  = 8'($urandom);
                op1 = 3'($urandom);
            end
            rst = ($urandom_range(0, 39) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
